// File: rtl/if_stage_pkg.sv
// Shared constants, FSM encoding and buffer type for the instruction-fetch stage.
// Optional misaligned-PC trap is enabled by defining IF_ADEL_CHECK_EN.
package if_stage_pkg;

    localparam logic [31:0] PC_INIT    = 32'hBFC0_0000;
    localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;
    localparam logic        RST_ENABLE = 1'b0;

    localparam int          STALL_BUS  = 2;
    localparam logic        STOP       = 1'b1;
    localparam logic        NOSTOP     = 1'b0;

    localparam int                    EXC_CODE_BUS = 5;
    localparam logic [EXC_CODE_BUS-1:0] EXC_NONE   = 5'h1f;
    localparam logic [EXC_CODE_BUS-1:0] EXC_ADEL   = 5'h04;

    typedef enum logic [1:0] {
        IF_REQ  = 2'd0,
        IF_DATA = 2'd1,
        IF_HOLD = 2'd2
    } if_state_e;

    typedef struct packed {
        logic [31:0]             inst;
        logic [EXC_CODE_BUS-1:0] exc;
        logic                    valid;
    } if_hold_t;

    function automatic logic [31:0] seq_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next fetch-PC priority mux: exception flush, then ID redirect, then sequential.
module pc_next_sel
    import if_stage_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        flush,
    input  logic [31:0] cp0_excaddr,
    input  logic        id_jump_en,
    input  logic [31:0] id_jump_addr,
    output logic [31:0] pc_next,
    output logic        redirect
);

    always_comb begin
        pc_next = seq_pc(pc);
        if (flush)
            pc_next = cp0_excaddr;
        else if (id_jump_en)
            pc_next = id_jump_addr;
    end

    assign redirect = flush | id_jump_en;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: REQ -> DATA -> HOLD handshake with instruction memory.
// Define IF_ADEL_CHECK_EN to trap misaligned PCs with EXC_ADEL instead of fetching.
module if_stage
    import if_stage_pkg::*;
(
    input  logic                    cpu_clk_50M,
    input  logic                    cpu_rst_n,
    input  logic [STALL_BUS-1:0]    stall,
    input  logic                    flush,
    input  logic [31:0]             cp0_excaddr,
    input  logic                    id_jump_en,
    input  logic [31:0]             id_jump_addr,
    output logic                    inst_req,
    output logic [31:0]             inst_addr,
    input  logic                    inst_addr_ok,
    input  logic                    inst_data_ok,
    input  logic [31:0]             inst_rdata,
    output logic [31:0]             if_pc,
    output logic [31:0]             if_pc_plus_4,
    output logic [31:0]             if_inst,
    output logic [EXC_CODE_BUS-1:0] if_exccode,
    output logic                    stallreq_if
);

    if_state_e   state, state_nx;
    logic [31:0] pc, pc_nx, npc;
    logic        discard, discard_nx;
    if_hold_t    hold_q, hold_nx;
    logic        redirect, adel, req_raw, consume;

    pc_next_sel u_pc_next_sel (
        .pc           (pc),
        .flush        (flush),
        .cp0_excaddr  (cp0_excaddr),
        .id_jump_en   (id_jump_en),
        .id_jump_addr (id_jump_addr),
        .pc_next      (npc),
        .redirect     (redirect)
    );

`ifdef IF_ADEL_CHECK_EN
    assign adel = (pc[1:0] != 2'b00);
`else
    assign adel = 1'b0;
`endif

    // Leaving HOLD also waits on stall[1]: the held word must not be replaced
    // while the IF/ID register has not latched it.
    assign consume = (stall[0] == NOSTOP) && (stall[1] == NOSTOP);

    always_comb begin
        state_nx   = state;
        pc_nx      = pc;
        discard_nx = discard;
        hold_nx    = hold_q;
        req_raw    = 1'b0;
        case (state)
            IF_REQ: begin
                req_raw = !adel;
                if (redirect) begin
                    pc_nx = npc;
                    // address already accepted: its response must be dropped
                    if (inst_addr_ok && !adel) begin
                        state_nx   = IF_DATA;
                        discard_nx = 1'b1;
                    end
                end else if (adel) begin
                    state_nx = IF_HOLD;
                    hold_nx  = '{inst: ZERO_WORD, exc: EXC_ADEL, valid: 1'b1};
                end else if (inst_addr_ok) begin
                    state_nx = IF_DATA;
                end
            end
            IF_DATA: begin
                if (redirect) begin
                    pc_nx      = npc;
                    discard_nx = 1'b1;
                end
                if (inst_data_ok) begin
                    discard_nx = 1'b0;
                    if (discard || redirect) begin
                        state_nx = IF_REQ;
                    end else begin
                        state_nx = IF_HOLD;
                        hold_nx  = '{inst: inst_rdata, exc: EXC_NONE, valid: 1'b1};
                    end
                end
            end
            IF_HOLD: begin
                if (flush || consume) begin
                    pc_nx         = npc;
                    state_nx      = IF_REQ;
                    hold_nx.valid = 1'b0;
                end
            end
            default: state_nx = IF_REQ;
        endcase
    end

    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst_n == RST_ENABLE) begin
            state   <= IF_REQ;
            pc      <= PC_INIT;
            discard <= 1'b0;
            hold_q  <= '{inst: ZERO_WORD, exc: EXC_NONE, valid: 1'b0};
        end else begin
            state   <= state_nx;
            pc      <= pc_nx;
            discard <= discard_nx;
            hold_q  <= hold_nx;
        end
    end

    assign inst_req     = (cpu_rst_n != RST_ENABLE) && req_raw;
    assign inst_addr    = pc;
    assign if_pc        = pc;
    assign if_pc_plus_4 = hold_q.valid ? seq_pc(pc) : ZERO_WORD;
    assign if_inst      = hold_q.valid ? hold_q.inst : ZERO_WORD;
    assign if_exccode   = hold_q.valid ? hold_q.exc : EXC_NONE;
    assign stallreq_if  = (state != IF_HOLD);

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus a randomized stream
// checked against a fetch-order model (expected PC sequence and memory contents).
module tb_if_stage;
    import if_stage_pkg::*;

    localparam logic [31:0] PC0 = 32'hBFC0_0000;

    logic                    cpu_clk_50M = 1'b0;
    logic                    cpu_rst_n;
    logic [STALL_BUS-1:0]    stall;
    logic                    flush;
    logic [31:0]             cp0_excaddr;
    logic                    id_jump_en;
    logic [31:0]             id_jump_addr;
    logic                    inst_req;
    logic [31:0]             inst_addr;
    logic                    inst_addr_ok;
    logic                    inst_data_ok;
    logic [31:0]             inst_rdata;
    logic [31:0]             if_pc;
    logic [31:0]             if_pc_plus_4;
    logic [31:0]             if_inst;
    logic [EXC_CODE_BUS-1:0] if_exccode;
    logic                    stallreq_if;

    int n_chk = 0;
    int n_pass = 0;

    if_stage dut (
        .cpu_clk_50M  (cpu_clk_50M),
        .cpu_rst_n    (cpu_rst_n),
        .stall        (stall),
        .flush        (flush),
        .cp0_excaddr  (cp0_excaddr),
        .id_jump_en   (id_jump_en),
        .id_jump_addr (id_jump_addr),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .if_pc        (if_pc),
        .if_pc_plus_4 (if_pc_plus_4),
        .if_inst      (if_inst),
        .if_exccode   (if_exccode),
        .stallreq_if  (stallreq_if)
    );

    always #10 cpu_clk_50M = ~cpu_clk_50M;

    // instruction memory contents as a pure function of the address
    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
    endfunction

    task automatic tick();
        @(negedge cpu_clk_50M);
    endtask

    task automatic idle();
        stall = '0; flush = 1'b0; cp0_excaddr = '0; id_jump_en = 1'b0;
        id_jump_addr = '0; inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = '0;
    endtask

    task automatic do_reset();
        idle();
        cpu_rst_n = 1'b0;
        tick(); tick();
        cpu_rst_n = 1'b1;
        #1;
    endtask

    // one fetch with 1-cycle addr_ok and 1-cycle data_ok; ends in HOLD
    task automatic drive_fetch();
        logic [31:0] a;
        a = inst_addr;
        inst_addr_ok = 1'b1; tick(); inst_addr_ok = 1'b0;
        inst_data_ok = 1'b1; inst_rdata = memf(a); tick(); inst_data_ok = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        cpu_rst_n = 1'b0;
        inst_data_ok = 1'b1; inst_rdata = 32'hDEAD_BEEF;
        tick();
        n_chk++;
        if ({inst_req, if_pc, if_pc_plus_4, if_inst, if_exccode} !== {1'b0, PC0, 32'h0, 32'h0, EXC_NONE})
            $display("FAIL reset_values: req %b pc %h pc4 %h inst %h exc %h, want 0 %h 0 0 %h",
                     inst_req, if_pc, if_pc_plus_4, if_inst, if_exccode, PC0, EXC_NONE);
        else n_pass++;
        tick();
        inst_data_ok = 1'b0;
        cpu_rst_n = 1'b1;
        #1;
        n_chk++;
        if ({inst_req, inst_addr} !== {1'b1, PC0})
            $display("FAIL first_req: req %b addr %h, want 1 %h", inst_req, inst_addr, PC0);
        else n_pass++;
    endtask

    task automatic test_basic_fetch();
        logic [31:0] e;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            e = PC0 + 32'(4 * k);
            n_chk++;
            if ({inst_req, inst_addr, stallreq_if} !== {1'b1, e, 1'b1})
                $display("FAIL basic_req%0d: req %b addr %h sreq %b, want 1 %h 1", k, inst_req, inst_addr, stallreq_if, e);
            else n_pass++;
            inst_addr_ok = 1'b1; tick(); inst_addr_ok = 1'b0;
            n_chk++;
            if ({inst_req, stallreq_if} !== 2'b01)
                $display("FAIL basic_data%0d: req %b sreq %b, want 0 1", k, inst_req, stallreq_if);
            else n_pass++;
            inst_data_ok = 1'b1; inst_rdata = memf(e); tick(); inst_data_ok = 1'b0;
            n_chk++;
            if ({stallreq_if, if_pc, if_pc_plus_4, if_inst, if_exccode} !== {1'b0, e, e + 32'd4, memf(e), EXC_NONE})
                $display("FAIL basic_out%0d: sreq %b pc %h pc4 %h inst %h exc %h, want 0 %h %h %h %h",
                         k, stallreq_if, if_pc, if_pc_plus_4, if_inst, if_exccode, e, e + 32'd4, memf(e), EXC_NONE);
            else n_pass++;
            tick();
            n_chk++;
            if ({stallreq_if, if_inst} !== {1'b1, 32'h0})
                $display("FAIL basic_after%0d: sreq %b inst %h, want 1 0", k, stallreq_if, if_inst);
            else n_pass++;
        end
    endtask

    task automatic test_stall_hold();
        do_reset();
        drive_fetch();
        stall = 2'b01;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_chk++;
            if ({inst_req, stallreq_if, if_pc} !== {1'b0, 1'b0, PC0})
                $display("FAIL stall_hold%0d: req %b sreq %b pc %h, want 0 0 %h", i, inst_req, stallreq_if, if_pc, PC0);
            else n_pass++;
        end
        stall = 2'b00;
        tick();
        n_chk++;
        if ({inst_req, inst_addr} !== {1'b1, PC0 + 32'd4})
            $display("FAIL stall_release: req %b addr %h, want 1 %h", inst_req, inst_addr, PC0 + 32'd4);
        else n_pass++;
    endtask

    task automatic test_redirect();
        do_reset();
        inst_addr_ok = 1'b1; tick(); inst_addr_ok = 1'b0;
        id_jump_en = 1'b1; id_jump_addr = 32'hBFC0_0100; tick(); id_jump_en = 1'b0;
        inst_data_ok = 1'b1; inst_rdata = memf(PC0); tick(); inst_data_ok = 1'b0;
        n_chk++;
        if ({stallreq_if, if_inst, inst_req, inst_addr} !== {1'b1, 32'h0, 1'b1, 32'hBFC0_0100})
            $display("FAIL jump_in_data: sreq %b inst %h req %b addr %h, want 1 0 1 bfc00100",
                     stallreq_if, if_inst, inst_req, inst_addr);
        else n_pass++;
        drive_fetch();
        n_chk++;
        if ({if_pc, if_inst} !== {32'hBFC0_0100, memf(32'hBFC0_0100)})
            $display("FAIL jump_target_fetch: pc %h inst %h, want bfc00100 %h", if_pc, if_inst, memf(32'hBFC0_0100));
        else n_pass++;
        tick();
        // jump in the same cycle as addr_ok: that response is dropped too
        inst_addr_ok = 1'b1; id_jump_en = 1'b1; id_jump_addr = 32'hBFC0_0200; tick();
        inst_addr_ok = 1'b0; id_jump_en = 1'b0;
        inst_data_ok = 1'b1; inst_rdata = memf(32'hBFC0_0104); tick(); inst_data_ok = 1'b0;
        n_chk++;
        if ({stallreq_if, inst_req, inst_addr} !== {1'b1, 1'b1, 32'hBFC0_0200})
            $display("FAIL jump_with_addr_ok: sreq %b req %b addr %h, want 1 1 bfc00200", stallreq_if, inst_req, inst_addr);
        else n_pass++;
        // jump in REQ before addr_ok simply retargets
        id_jump_en = 1'b1; id_jump_addr = 32'hBFC0_0300; tick(); id_jump_en = 1'b0;
        n_chk++;
        if ({inst_req, inst_addr} !== {1'b1, 32'hBFC0_0300})
            $display("FAIL jump_in_req: req %b addr %h, want 1 bfc00300", inst_req, inst_addr);
        else n_pass++;
        drive_fetch();
        n_chk++;
        if ({stallreq_if, if_pc, if_inst} !== {1'b0, 32'hBFC0_0300, memf(32'hBFC0_0300)})
            $display("FAIL retarget_fetch: sreq %b pc %h inst %h, want 0 bfc00300 %h",
                     stallreq_if, if_pc, if_inst, memf(32'hBFC0_0300));
        else n_pass++;
    endtask

    task automatic test_flush_priority();
        do_reset();
        flush = 1'b1; cp0_excaddr = 32'hBFC0_0380; id_jump_en = 1'b1; id_jump_addr = 32'hBFC0_0100;
        tick(); idle();
        n_chk++;
        if ({inst_req, inst_addr} !== {1'b1, 32'hBFC0_0380})
            $display("FAIL flush_vs_jump: req %b addr %h, want 1 bfc00380", inst_req, inst_addr);
        else n_pass++;
        drive_fetch();
        stall = 2'b01; flush = 1'b1; cp0_excaddr = 32'hBFC0_0500; id_jump_en = 1'b1; id_jump_addr = 32'hBFC0_0600;
        tick(); idle();
        n_chk++;
        if ({stallreq_if, if_inst, inst_req, inst_addr} !== {1'b1, 32'h0, 1'b1, 32'hBFC0_0500})
            $display("FAIL flush_in_hold: sreq %b inst %h req %b addr %h, want 1 0 1 bfc00500",
                     stallreq_if, if_inst, inst_req, inst_addr);
        else n_pass++;
    endtask

    task automatic test_misaligned();
        do_reset();
        id_jump_en = 1'b1; id_jump_addr = 32'hBFC0_0102; tick(); id_jump_en = 1'b0;
`ifdef IF_ADEL_CHECK_EN
        n_chk++;
        if (inst_req !== 1'b0)
            $display("FAIL adel_no_req: req %b, want 0", inst_req);
        else n_pass++;
        stall = 2'b01;
        tick();
        n_chk++;
        if ({inst_req, stallreq_if, if_exccode, if_pc, if_inst} !== {1'b0, 1'b0, EXC_ADEL, 32'hBFC0_0102, 32'h0})
            $display("FAIL adel_hold: req %b sreq %b exc %h pc %h inst %h, want 0 0 %h bfc00102 0",
                     inst_req, stallreq_if, if_exccode, if_pc, if_inst, EXC_ADEL);
        else n_pass++;
        stall = 2'b00;
`else
        n_chk++;
        if ({inst_req, inst_addr} !== {1'b1, 32'hBFC0_0102})
            $display("FAIL unaligned_req: req %b addr %h, want 1 bfc00102", inst_req, inst_addr);
        else n_pass++;
        drive_fetch();
        n_chk++;
        if ({stallreq_if, if_exccode, if_pc} !== {1'b0, EXC_NONE, 32'hBFC0_0102})
            $display("FAIL unaligned_out: sreq %b exc %h pc %h, want 0 %h bfc00102", stallreq_if, if_exccode, if_pc, EXC_NONE);
        else n_pass++;
`endif
    endtask

    task automatic test_reset_in_data();
        do_reset();
        drive_fetch();
        tick();
        inst_addr_ok = 1'b1; tick(); inst_addr_ok = 1'b0;
        cpu_rst_n = 1'b0;
        tick();
        n_chk++;
        if ({inst_req, stallreq_if, if_pc, if_pc_plus_4, if_inst, if_exccode} !== {1'b0, 1'b1, PC0, 32'h0, 32'h0, EXC_NONE})
            $display("FAIL rst_in_data: req %b sreq %b pc %h pc4 %h inst %h exc %h, want 0 1 %h 0 0 %h",
                     inst_req, stallreq_if, if_pc, if_pc_plus_4, if_inst, if_exccode, PC0, EXC_NONE);
        else n_pass++;
        cpu_rst_n = 1'b1;
        inst_data_ok = 1'b1; inst_rdata = memf(PC0 + 32'd4);
        tick();
        inst_data_ok = 1'b0;
        n_chk++;
        if ({inst_req, inst_addr, stallreq_if, if_inst} !== {1'b1, PC0, 1'b1, 32'h0})
            $display("FAIL late_data_ignored: req %b addr %h sreq %b inst %h, want 1 %h 1 0",
                     inst_req, inst_addr, stallreq_if, if_inst, PC0);
        else n_pass++;
        drive_fetch();
        n_chk++;
        if ({if_pc, if_inst} !== {PC0, memf(PC0)})
            $display("FAIL post_rst_fetch: pc %h inst %h, want %h %h", if_pc, if_inst, PC0, memf(PC0));
        else n_pass++;
    endtask

    task automatic test_random_stream();
        logic [31:0] exp_addr, pend_addr;
        bit          pend, given;
        int          cnt, consumed;
        do_reset();
        exp_addr = PC0; pend = 0; given = 0; cnt = 0; consumed = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            inst_addr_ok = 1'b0; inst_data_ok = 1'b0; stall = 2'b00; id_jump_en = 1'b0;
            if (stallreq_if === 1'b0) begin
                n_chk++;
                if (!given || if_pc !== exp_addr || if_inst !== memf(exp_addr))
                    $display("FAIL rand_deliver@%0d: pc %h inst %h returned %0d, want pc %h inst %h",
                             cyc, if_pc, if_inst, given, exp_addr, memf(exp_addr));
                else n_pass++;
                if ($urandom_range(3) == 0) begin
                    stall = ($urandom_range(1) != 0) ? 2'b11 : 2'b01;
                end else begin
                    consumed++;
                    given = 0;
                    if ($urandom_range(4) == 0) begin
                        id_jump_en   = 1'b1;
                        id_jump_addr = PC0 + ($urandom_range(255) << 2);
                        exp_addr     = id_jump_addr;
                    end else begin
                        exp_addr = exp_addr + 32'd4;
                    end
                end
            end
            if (pend) begin
                if (cnt == 0) begin
                    inst_data_ok = 1'b1; inst_rdata = memf(pend_addr); pend = 0; given = 1;
                end else begin
                    cnt--;
                end
            end else if (inst_req === 1'b1 && $urandom_range(2) != 0) begin
                inst_addr_ok = 1'b1;
                n_chk++;
                if (inst_addr !== exp_addr)
                    $display("FAIL rand_addr@%0d: addr %h, want %h", cyc, inst_addr, exp_addr);
                else n_pass++;
                pend = 1; pend_addr = inst_addr; cnt = int'($urandom_range(2));
            end
            tick();
        end
        idle();
        n_chk++;
        if (consumed < 40)
            $display("FAIL rand_progress: %0d instructions delivered, want at least 40", consumed);
        else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        idle();
        cpu_rst_n = 1'b0;
        test_reset();
        test_basic_fetch();
        test_stall_hold();
        test_redirect();
        test_flush_priority();
        test_misaligned();
        test_reset_in_data();
        test_random_stream();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The block SHALL have these ports, one per line: name, direction, width, meaning. Clock and reset come first.
- cpu_clk_50M  in  1  single clock, all state on its rising edge.
- cpu_rst_n  in  1  reset, synchronous, active-low.
- stall  in  STALL_BUS  pipeline stall vector; stall[0] freezes the PC, stall[1] freezes the IF/ID capture.
- flush  in  1  exception flush.
- cp0_excaddr  in  32  exception handler address, used when flush=1.
- id_jump_en  in  1  branch/jump taken in ID.
- id_jump_addr  in  32  branch/jump target.
- inst_req  out  1  fetch request to instruction memory.
- inst_addr  out  32  fetch address.
- inst_addr_ok  in  1  memory accepted the request this cycle.
- inst_data_ok  in  1  instruction data returned this cycle.
- inst_rdata  in  32  returned instruction.
- if_pc  out  32  PC of the delivered instruction.
- if_pc_plus_4  out  32  if_pc+4.
- if_inst  out  32  delivered instruction, ZERO_WORD when not valid.
- if_exccode  out  EXC_CODE_BUS  EXC_NONE or EXC_ADEL.
- stallreq_if  out  1  asks the stall controller to freeze; 1 while no valid instruction is held.

Function
REQ-002 The block SHALL keep a 32-bit fetch PC.
- next PC priority: flush→cp0_excaddr; else id_jump_en→id_jump_addr; else PC+4, wrapping modulo 2^32.
REQ-003 The block SHALL implement the FSM REQ → DATA → HOLD.
- REQ: inst_req=1, inst_addr=PC; on inst_addr_ok go to DATA.
- DATA: inst_req=0; on inst_data_ok capture inst_rdata into the buffer and go to HOLD.
- HOLD: outputs are valid and stallreq_if=0; when stall[0]=NOSTOP, the PC advances and the FSM returns to REQ on the next cycle.
REQ-004 Best-case latency SHALL be 2 cycles from REQ entry to valid output, given addr_ok in cycle 0 and data_ok in cycle 1.
REQ-005 stallreq_if SHALL be 1 in REQ and in DATA, and 0 in HOLD.
REQ-006 A flush or jump arriving in REQ (with no addr_ok yet) SHALL retarget inst_addr in the following cycle with no discard.
- Once inst_addr_ok is seen, the address is committed for that transaction.
REQ-007 A flush or jump arriving in DATA, or in the same cycle as inst_addr_ok, SHALL set a discard flag.
- The matching data_ok is consumed and dropped; the FSM re-enters REQ at the new PC.
REQ-008 A flush in HOLD SHALL invalidate the buffer, load cp0_excaddr, and go to REQ.
- A jump in HOLD with stall[0]=NOSTOP loads id_jump_addr.
REQ-009 When flush and id_jump_en are asserted together, flush SHALL win.
REQ-010 When inst_addr_ok and inst_data_ok are asserted together in REQ, the response SHALL NOT be consumed.
- The response is consumed only in DATA; the memory guarantees data_ok is at least 1 cycle after addr_ok.

Reset
REQ-011 While cpu_rst_n=0 at a clock edge, the block SHALL reset to the following values, with any outstanding transaction abandoned:
- PC=PC_INIT (0xBFC00000), FSM=REQ, discard=0, buffer invalid.
- if_pc=PC_INIT, if_pc_plus_4=ZERO_WORD, if_inst=ZERO_WORD, if_exccode=EXC_NONE.
- inst_req=0 during the reset cycle.
REQ-012 After reset release, the first inst_req SHALL issue in the first cycle with cpu_rst_n=1, at PC_INIT.

Configuration
REQ-013 With IF_ADEL_CHECK_EN defined, a PC with PC[1:0]≠0 SHALL NOT issue inst_req.
- The FSM jumps directly to HOLD with if_inst=ZERO_WORD and if_exccode=EXC_ADEL.
REQ-014 Without IF_ADEL_CHECK_EN, PC[1:0] SHALL be ignored, the address SHALL be issued as-is, and if_exccode SHALL always be EXC_NONE.

Structure
REQ-015 The following constants SHALL live in the shared defines file, none of them local: PC_INIT, ZERO_WORD, STALL_BUS, STOP/NOSTOP, EXC_CODE_BUS, EXC_NONE, EXC_ADEL, RST_ENABLE, and the FSM state encodings.
REQ-016 The block SHALL contain one sub-module, pc_next_sel: the combinational next-PC priority mux. Everything else is flat.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
- Reset release, memory addr_ok and data_ok 1 cycle each: inst_addr=0xBFC00000, then 0xBFC00004; if_inst matches rdata; stallreq_if low 1 cycle per fetch.
- stall[0]=STOP for 3 cycles in HOLD: if_pc stays constant and no new inst_req.
- Jump to 0xBFC00100 while in DATA: the returned word is dropped (not presented) and the next inst_addr is 0xBFC00100.
- flush with cp0_excaddr=0xBFC00380 and id_jump_en=1 in the same cycle: the next inst_addr is 0xBFC00380.
- With IF_ADEL_CHECK_EN, jump target 0xBFC00102: no inst_req, if_exccode=EXC_ADEL, if_pc=0xBFC00102.
- cpu_rst_n low while in DATA: outputs return to reset values and the late data_ok is ignored.
